vga_pixel_scan: RTL and testbench
=================================

# vga_pixel_scan

Parametrised VGA scan-out engine: generates horizontal/vertical timing from a single pixel clock, pulls packed pixel words from a show-ahead FIFO, and unpacks them at 1, 2, 4, 8 or 16 bits per pixel onto R/G/B. It sits between the frame-buffer read FIFO (filled by the Avalon master) and the VGA DAC pins. It replaces the fixed 1-bit scanner and adds underflow detection, selectable sync polarity, and vertical timing derived on the pixel clock.

## Interface
- H_DISPLAY, 640, active pixels per line; must be a multiple of PPW = WORD_W/BPP
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_DISPLAY, 480, active lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- WORD_W, 16, FIFO word width
- BPP, 1, bits per pixel: 1, 2, 4, 8 or 16; BPP=16 requires WORD_W=16
- COLOR_W, 2, bits per colour channel; 1..5
- HS_POL / VS_POL, 0 / 0, active level of Hs/Vs during sync (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock; sole clock
- reset  in  1  asynchronous, active-high
- fifo_read_read  out  1  pop request; combinational
- fifo_read_data  in  WORD_W  show-ahead head word; valid when !fifo_read_empty
- fifo_read_empty  in  1  FIFO empty
- Hs, Vs  out  1  sync outputs at the polarity set by HS_POL/VS_POL
- DE  out  1  display enable
- R, G, B  out  COLOR_W each  pixel colour; 0 whenever DE=0
- frame_start  out  1  one-cycle pulse, registered, for the first active pixel of each frame
- underflow  out  1  sticky; set on any missed fetch; cleared at frame_start

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK). v_cnt 0..V_TOTAL-1 advances when h_cnt wraps. v_cnt wraps to 0 after V_TOTAL-1. No second clock domain.
- active = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- Hsync region: h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC).
- Vsync region: v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC), for whole lines.
- Fetch: fetch slot = active && (h_cnt % PPW == 0).
  - fifo_read_read = fetch slot && !fifo_read_empty.
  - Popped word loads the shift register.
  - Fetch slot with FIFO empty: no pop, shift register loads 0 (black group), underflow <= 1.
  - No reads outside fetch slots, including blanking.
- Unpack: pixels are taken LSB-first. Pixel k of a word is bits [k*BPP +: BPP]. The register shifts right by BPP each active clock.
- Colour mapping:
  - BPP=16: RGB565; R/G/B take the top COLOR_W bits of [15:11], [10:5], [4:0].
  - BPP<16: greyscale, same value on all three channels.
    - BPP >= COLOR_W: take the top COLOR_W bits of the pixel.
    - BPP < COLOR_W: replicate the pixel bits MSB-first to fill COLOR_W (1-bit pixel 1 gives all ones).
- underflow: set by a missed fetch. frame_start clears it; a missed fetch in the same cycle wins.

## Timing
- Reset values: all counters 0, shift register 0, DE=0, R=G=B=0, Hs=!HS_POL, Vs=!VS_POL, frame_start=0, underflow=0. fifo_read_read follows its equation from counter (0,0); with data present it is 1 in the first cycle after reset release.
- Latency: DE, Hs, Vs, R/G/B and frame_start are all registered and all lag the counter state by exactly 1 clock, so they stay mutually aligned.
- Pop-to-pixel: the word popped at counter h appears as pixel 0 on the outputs 1 clock later. Pixels 1..PPW-1 follow on consecutive clocks.
- BPP=16 (PPW=1): a pop on every active clock, H_DISPLAY pops per line.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). Scan restarts at (0,0). No FIFO flush is issued here; the owner of the FIFO flushes it.

## Structure
- Package vga_pixel_pkg holds:
  - default 640x480@60 timing constants
  - derived H_TOTAL/V_TOTAL/PPW functions
  - colour-expand function (pixel, BPP, COLOR_W) -> channel
  - elaboration checks: H_DISPLAY % PPW == 0, legal BPP
- Sub-module vga_timing_gen contains the counters, the active/sync region decode and the frame_start source. It is reusable by the text-mode block.
- The top level contains only fetch, shift register, colour mapping and the output register stage.

## Test plan
- Small timing (H 8/2/2/2, V 4/1/1/1), BPP=1, COLOR_W=2, FIFO word 16'h00F0 always available -> Hs low for 2 clocks per 14-clock line. Vs low for 1 line of 7. Line pixels 0..7 = 0,0,0,0,3,3,3,3.
- BPP=4, COLOR_W=2, word 16'h8421 -> successive pixels on R=G=B: 0,0,1,2. One pop per 4 active clocks, zero pops in blanking.
- BPP=16, COLOR_W=2, word 16'hF81F -> R=3, G=0, B=3. fifo_read_read high on every active clock, pixel 1 clock after pop.
- FIFO empty for one fetch slot mid-line -> no pop that cycle, that group black, underflow=1 until next frame_start. The next frame with a full FIFO keeps underflow=0.
- HS_POL=1, VS_POL=1 -> syncs active-high. After reset Hs=Vs=0, DE=0, RGB=0. First frame_start lands 1 clock after reset release.
- Assert reset at mid-line h=5 -> outputs at reset values the same cycle. After release the first pop and frame_start repeat the post-reset sequence exactly.

Source files
------------

// File: rtl/vga_pixel_pkg.sv
// Shared constants and helpers for the VGA scan-out blocks: default 640x480@60
// timing, derived totals, configuration legality and pixel-to-channel expansion.
package vga_pixel_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_WORD_W    = 16;
    localparam int DEF_BPP       = 1;
    localparam int DEF_COLOR_W   = 2;

    function automatic int calc_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int calc_ppw(input int word_w, input int bpp);
        return word_w / bpp;
    endfunction

    function automatic bit bpp_legal(input int bpp, input int word_w);
        case (bpp)
            1, 2, 4, 8: return (word_w % bpp) == 0;
            16:         return word_w == 16;
            default:    return 1'b0;
        endcase
    endfunction

    // Wide pixels keep their top bits; narrow pixels are repeated MSB-first to fill the channel.
    function automatic logic [4:0] color_expand(input logic [15:0] pix, input int bpp, input int color_w);
        int p;
        int rep;
        int val;
        p = int'(pix) & ((1 << bpp) - 1);
        if (bpp >= color_w) begin
            val = p >> (bpp - color_w);
        end else begin
            rep = 0;
            for (int j = 0; j < 5; j++) begin
                rep = (rep << bpp) | p;
            end
            val = rep >> (5 * bpp - color_w);
        end
        return 5'(val & 31);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters with active, sync and frame-start decode; shared with the text-mode block.
module vga_timing_gen
    import vga_pixel_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          vga_clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_first
);

    localparam int H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DISP_L = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_START = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DISP_L = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VS_START = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;

    // Pixel counter wraps each line; line counter advances on that wrap.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= {HW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= {VW{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + VW'(1'b1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1'b1);
            v_cnt_r <= v_cnt_r;
        end
    end

    // Region decode from the current counter state.
    always_comb begin
        h_cnt       = h_cnt_r;
        v_cnt       = v_cnt_r;
        active      = (h_cnt_r < H_DISP_L) && (v_cnt_r < V_DISP_L);
        hsync       = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
        vsync       = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
        frame_first = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    end

endmodule

// File: rtl/vga_pixel_scan.sv
// VGA scan-out: fetches packed words from a show-ahead FIFO, unpacks them LSB-first
// and drives registered sync, enable and colour pins.
module vga_pixel_scan
    import vga_pixel_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int BPP       = DEF_BPP,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic               fifo_read_read,
    input  logic [WORD_W-1:0]  fifo_read_data,
    input  logic               fifo_read_empty,
    output logic               Hs,
    output logic               Vs,
    output logic               DE,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               frame_start,
    output logic               underflow
);

    localparam int H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int PPW     = calc_ppw(WORD_W, BPP);

    if (!bpp_legal(BPP, WORD_W)) begin : g_bad_bpp
        $error("vga_pixel_scan: illegal BPP/WORD_W combination");
    end
    if ((H_DISPLAY % PPW) != 0) begin : g_bad_hdisp
        $error("vga_pixel_scan: H_DISPLAY must be a multiple of pixels per word");
    end
    if ((COLOR_W < 1) || (COLOR_W > 5)) begin : g_bad_cw
        $error("vga_pixel_scan: COLOR_W must be 1..5");
    end

    logic [HW-1:0]      h_cnt_s;
    logic [VW-1:0]      v_cnt_s;
    logic               active_s;
    logic               hsync_s;
    logic               vsync_s;
    logic               frame_first_s;
    logic               fetch_slot_s;
    logic               missed_s;
    logic [WORD_W-1:0]  cur_word_s;
    logic [WORD_W-1:0]  shift_r;
    logic [15:0]        pix16_s;
    logic [COLOR_W-1:0] r_s;
    logic [COLOR_W-1:0] g_s;
    logic [COLOR_W-1:0] b_s;

    vga_timing_gen #(
        .H_DISPLAY (H_DISPLAY),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_DISPLAY (V_DISPLAY),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .HW        (HW),
        .VW        (VW)
    ) u_timing (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .h_cnt       (h_cnt_s),
        .v_cnt       (v_cnt_s),
        .active      (active_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .frame_first (frame_first_s)
    );

    // Fetch decision; a missed fetch substitutes a black word so the group still displays.
    always_comb begin
        fetch_slot_s   = active_s && ((int'(h_cnt_s) % PPW) == 0);
        fifo_read_read = fetch_slot_s && !fifo_read_empty;
        missed_s       = fetch_slot_s && fifo_read_empty;
        if (fetch_slot_s) begin
            if (fifo_read_empty) begin
                cur_word_s = {WORD_W{1'b0}};
            end else begin
                cur_word_s = fifo_read_data;
            end
        end else begin
            cur_word_s = shift_r;
        end
    end

    // Colour mapping of the pixel in the low bits of the current word.
    always_comb begin
        pix16_s = 16'(cur_word_s[BPP-1:0]);
        r_s     = {COLOR_W{1'b0}};
        g_s     = {COLOR_W{1'b0}};
        b_s     = {COLOR_W{1'b0}};
        if (BPP == 16) begin
            r_s = COLOR_W'(color_expand({11'b0, pix16_s[15:11]}, 5, COLOR_W));
            g_s = COLOR_W'(color_expand({10'b0, pix16_s[10:5]}, 6, COLOR_W));
            b_s = COLOR_W'(color_expand({11'b0, pix16_s[4:0]}, 5, COLOR_W));
        end else begin
            r_s = COLOR_W'(color_expand(pix16_s, BPP, COLOR_W));
            g_s = r_s;
            b_s = r_s;
        end
    end

    // Unpack register: shifts the displayed pixel out on every active clock.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            shift_r <= {WORD_W{1'b0}};
        end else if (active_s) begin
            shift_r <= cur_word_s >> BPP;
        end else begin
            shift_r <= shift_r;
        end
    end

    // Output stage: everything lags the counters by one clock and stays aligned.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DE          <= 1'b0;
            Hs          <= ~HS_POL;
            Vs          <= ~VS_POL;
            R           <= {COLOR_W{1'b0}};
            G           <= {COLOR_W{1'b0}};
            B           <= {COLOR_W{1'b0}};
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            DE          <= active_s;
            Hs          <= hsync_s ? HS_POL : ~HS_POL;
            Vs          <= vsync_s ? VS_POL : ~VS_POL;
            R           <= active_s ? r_s : {COLOR_W{1'b0}};
            G           <= active_s ? g_s : {COLOR_W{1'b0}};
            B           <= active_s ? b_s : {COLOR_W{1'b0}};
            frame_start <= frame_first_s;
            if (missed_s) begin
                underflow <= 1'b1;
            end else if (frame_first_s) begin
                underflow <= 1'b0;
            end else begin
                underflow <= underflow;
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_scan.sv
// Three scanners (1, 4 and 16 bpp) on a small raster, checked cycle by cycle
// against a position-based reference model of the scan-out rules.
module tb_vga_pixel_scan;

    localparam int HD = 8, HF = 2, HSW = 2, HB = 2, HT = 14;
    localparam int VD = 4, VF = 1, VSW = 1, VB = 1, VT = 7;
    localparam int CW = 2;
    localparam int N  = 3;

    const int          PPW_C[N] = '{8, 4, 1};
    const int          BPP_C[N] = '{1, 4, 16};
    const int          WW_C[N]  = '{8, 16, 16};
    const int          HP_C[N]  = '{0, 1, 0};
    const int          VP_C[N]  = '{0, 1, 0};
    const logic [15:0] FIX_C[N] = '{16'h00F0, 16'h8421, 16'hF81F};

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    logic [15:0]   dat[N];
    logic          emp[N];
    logic          rd[N], hs[N], vs[N], de[N], fs[N], uf[N];
    logic [CW-1:0] r[N], g[N], b[N];

    vga_pixel_scan #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .WORD_W(8), .BPP(1), .COLOR_W(CW), .HS_POL(1'b0), .VS_POL(1'b0))
    u_bpp1 (.vga_clk(vga_clk), .reset(reset), .fifo_read_read(rd[0]), .fifo_read_data(dat[0][7:0]),
            .fifo_read_empty(emp[0]), .Hs(hs[0]), .Vs(vs[0]), .DE(de[0]), .R(r[0]), .G(g[0]), .B(b[0]),
            .frame_start(fs[0]), .underflow(uf[0]));

    vga_pixel_scan #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .WORD_W(16), .BPP(4), .COLOR_W(CW), .HS_POL(1'b1), .VS_POL(1'b1))
    u_bpp4 (.vga_clk(vga_clk), .reset(reset), .fifo_read_read(rd[1]), .fifo_read_data(dat[1]),
            .fifo_read_empty(emp[1]), .Hs(hs[1]), .Vs(vs[1]), .DE(de[1]), .R(r[1]), .G(g[1]), .B(b[1]),
            .frame_start(fs[1]), .underflow(uf[1]));

    vga_pixel_scan #(.H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
                     .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
                     .WORD_W(16), .BPP(16), .COLOR_W(CW), .HS_POL(1'b0), .VS_POL(1'b0))
    u_bpp16 (.vga_clk(vga_clk), .reset(reset), .fifo_read_read(rd[2]), .fifo_read_data(dat[2]),
             .fifo_read_empty(emp[2]), .Hs(hs[2]), .Vs(vs[2]), .DE(de[2]), .R(r[2]), .G(g[2]), .B(b[2]),
             .frame_start(fs[2]), .underflow(uf[2]));

    int          n_assert = 0;
    int          n_fail   = 0;
    int          mh, mv;
    logic [15:0] hold[N];
    int          uf_m[N];
    int          e_de[N], e_hs[N], e_vs[N], e_r[N], e_g[N], e_b[N], e_fs[N], e_uf[N];

    task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] h=%0d v=%0d observed=%0h expected=%0h", tag, i, mh, mv, obs, exp);
        end
    endtask

    // Channel value of pixel k of word w: c=0 R, 1 G, 2 B.
    function automatic int ch_val(input int i, input logic [15:0] w, input int k, input int c);
        int bpp, p, rep, n;
        bpp = BPP_C[i];
        if (bpp == 16) begin
            if (c == 0) return ((int'(w) >> 11) & 31) >> (5 - CW);
            if (c == 1) return ((int'(w) >> 5) & 63) >> (6 - CW);
            return (int'(w) & 31) >> (5 - CW);
        end
        p = (int'(w) >> (k * bpp)) & ((1 << bpp) - 1);
        if (bpp >= CW) return p >> (bpp - CW);
        rep = 0;
        n   = 0;
        while (n < CW) begin
            rep = (rep << bpp) | p;
            n   = n + bpp;
        end
        return rep >> (n - CW);
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        for (int i = 0; i < N; i++) begin
            hold[i] = 16'h0000; uf_m[i] = 0;
            e_de[i] = 0; e_hs[i] = 1 - HP_C[i]; e_vs[i] = 1 - VP_C[i];
            e_r[i] = 0; e_g[i] = 0; e_b[i] = 0; e_fs[i] = 0; e_uf[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            chk("DE", i, 16'(de[i]), 16'(e_de[i]));
            chk("Hs", i, 16'(hs[i]), 16'(e_hs[i]));
            chk("Vs", i, 16'(vs[i]), 16'(e_vs[i]));
            chk("R", i, 16'(r[i]), 16'(e_r[i]));
            chk("G", i, 16'(g[i]), 16'(e_g[i]));
            chk("B", i, 16'(b[i]), 16'(e_b[i]));
            chk("frame_start", i, 16'(fs[i]), 16'(e_fs[i]));
            chk("underflow", i, 16'(uf[i]), 16'(e_uf[i]));
        end
    endtask

    // mode 0: fixed words; 1: random words, random empty; 2: random words, never empty;
    // 3: fixed words, one empty fetch slot on line 1.
    task automatic step(input int mode);
        int  k, act, slot;
        check_outputs();
        for (int i = 0; i < N; i++) begin
            if (mode == 1 || mode == 2) dat[i] = 16'($urandom);
            else dat[i] = FIX_C[i];
            if (WW_C[i] == 8) dat[i] = dat[i] & 16'h00FF;
            if (mode == 1) emp[i] = ($urandom_range(0, 5) == 0);
            else if (mode == 3) emp[i] = (mv == 1) && (mh == ((i == 0) ? 0 : 4));
            else emp[i] = 1'b0;
        end
        #1;
        act = (mh < HD && mv < VD) ? 1 : 0;
        for (int i = 0; i < N; i++) begin
            slot = (act != 0 && (mh % PPW_C[i]) == 0) ? 1 : 0;
            chk("fifo_read_read", i, 16'(rd[i]), 16'((slot != 0) && !emp[i]));
            if (slot != 0) hold[i] = emp[i] ? 16'h0000 : dat[i];
            k = mh % PPW_C[i];
            e_de[i] = act;
            e_hs[i] = (mh >= HD + HF && mh < HD + HF + HSW) ? HP_C[i] : 1 - HP_C[i];
            e_vs[i] = (mv >= VD + VF && mv < VD + VF + VSW) ? VP_C[i] : 1 - VP_C[i];
            e_r[i]  = (act != 0) ? ch_val(i, hold[i], k, 0) : 0;
            e_g[i]  = (act != 0) ? ch_val(i, hold[i], k, 1) : 0;
            e_b[i]  = (act != 0) ? ch_val(i, hold[i], k, 2) : 0;
            e_fs[i] = (mh == 0 && mv == 0) ? 1 : 0;
            if (slot != 0 && emp[i]) uf_m[i] = 1;
            else if (e_fs[i] != 0) uf_m[i] = 0;
            e_uf[i] = uf_m[i];
        end
        mh = mh + 1;
        if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end
        @(negedge vga_clk);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < N; i++) begin
            dat[i] = FIX_C[i];
            if (WW_C[i] == 8) dat[i] = dat[i] & 16'h00FF;
            emp[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge vga_clk);
        check_outputs();
        for (int i = 0; i < N; i++) chk("read_in_reset", i, 16'(rd[i]), 16'h0001);
        reset = 1'b0;

        repeat (2 * HT * VT) step(0);
        step(3);
        repeat (HT * VT - 1) step(3);
        repeat (HT * VT) step(0);
        repeat (2 * HT * VT) step(1);
        repeat (HT * VT + HT) step(2);

        guard = 0;
        while (!(mh == 5 && mv == 1) && guard < 2 * HT * VT) begin
            step(0);
            guard++;
        end
        chk("reach_mid_line", 0, 16'(guard < 2 * HT * VT), 16'h0001);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        for (int i = 0; i < N; i++) chk("read_after_reset", i, 16'(rd[i]), 16'h0001);
        @(negedge vga_clk);
        reset = 1'b0;
        repeat (HT * VT + HT) step(0);
        repeat (HT * VT) step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
